data_memory_arbiter: RTL

//  Shares the single-port data memory between two requesters: the CPU load/store path (port A, "cpu")
//  and a debug/program-loader port (port B, "dbg"). Each requester uses a req/ack handshake.
//  The arbiter round-robins between them and sequences one access at a time, IDLE -> ACCESS -> RESP.
//  It sits between the core/debug logic and data_memory, and drives all of that memory's control inputs.

---
 rtl/dmem_arb_pkg.sv | 37 +++
 rtl/dmem_arb_rr_select.sv | 23 ++
 rtl/data_memory_arbiter.sv | 170 +++++++++++++++++
 3 files changed

// File: rtl/dmem_arb_pkg.sv
// Shared types for the data-memory arbiter: FSM states, requester ids, access sizes
// and the request bundle captured in the hold register.
package dmem_arb_pkg;

   localparam int unsigned DMEM_ADDR_BITS = 32;
   localparam int unsigned DMEM_DATA_BITS = 32;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_ACCESS = 2'd1,
      ST_RESP   = 2'd2
   } arb_state_e;

   typedef enum logic {
      PORT_CPU = 1'b0,
      PORT_DBG = 1'b1
   } port_id_e;

   typedef enum logic [1:0] {
      SZ_BYTE = 2'b00,
      SZ_HALF = 2'b01,
      SZ_WORD = 2'b10
   } size_e;

   typedef struct packed {
      logic                      we;
      size_e                     size;
      logic                      sign_ext;
      logic [DMEM_ADDR_BITS-1:0] addr;
      logic [DMEM_DATA_BITS-1:0] wdata;
   } dmem_req_t;

   function automatic port_id_e other_port(input port_id_e p);
      return (p == PORT_CPU) ? PORT_DBG : PORT_CPU;
   endfunction

endpackage

// File: rtl/dmem_arb_rr_select.sv
// Two-way round-robin pick: a lone requester wins outright, a tie goes to the port
// that did not win last time.
module dmem_arb_rr_select
   import dmem_arb_pkg::*;
(
   input  logic     cpu_req,
   input  logic     dbg_req,
   input  port_id_e last_grant,
   output port_id_e grant_c,
   output logic     valid_c
);

   always_comb begin
      valid_c = cpu_req | dbg_req;
      grant_c = PORT_CPU;
      if (cpu_req && dbg_req) begin
         grant_c = other_port(last_grant);
      end else if (dbg_req) begin
         grant_c = PORT_DBG;
      end
   end

endmodule

// File: rtl/data_memory_arbiter.sv
// Shares the single-port data memory between the CPU and debug ports, one access at a
// time (IDLE -> ACCESS -> RESP). Define DMEM_ARB_STATS_EN to add saturating grant counters.
module data_memory_arbiter
   import dmem_arb_pkg::*;
#(
   parameter int unsigned ADDR_BITS = DMEM_ADDR_BITS,
`ifdef DMEM_ARB_STATS_EN
   parameter int unsigned STAT_BITS = 16,
`endif
   parameter int unsigned DATA_BITS = DMEM_DATA_BITS
)(
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 cpu_req,
   input  logic                 cpu_we,
   input  logic [1:0]           cpu_size,
   input  logic                 cpu_sign_ext,
   input  logic [ADDR_BITS-1:0] cpu_addr,
   input  logic [DATA_BITS-1:0] cpu_wdata,
   output logic                 cpu_ack,
   output logic [DATA_BITS-1:0] cpu_rdata,
   output logic                 cpu_fault,
   input  logic                 dbg_req,
   input  logic                 dbg_we,
   input  logic [1:0]           dbg_size,
   input  logic                 dbg_sign_ext,
   input  logic [ADDR_BITS-1:0] dbg_addr,
   input  logic [DATA_BITS-1:0] dbg_wdata,
   output logic                 dbg_ack,
   output logic [DATA_BITS-1:0] dbg_rdata,
   output logic                 dbg_fault,
   output logic                 mem_enable_read,
   output logic                 mem_enable_write,
   output logic [1:0]           mem_size,
   output logic                 mem_sign_ext,
   output logic [ADDR_BITS-1:0] mem_address,
   output logic [DATA_BITS-1:0] mem_data_to_write,
   input  logic [DATA_BITS-1:0] mem_data_read,
   input  logic                 mem_misaligned
`ifdef DMEM_ARB_STATS_EN
   ,
   output logic [STAT_BITS-1:0] cpu_grants,
   output logic [STAT_BITS-1:0] dbg_grants
`endif
);

   arb_state_e           state_q, state_d;
   port_id_e             last_grant_q, owner_q, grant_c;
   logic                 grant_valid_c;
   logic                 take_c, finish_c;
   dmem_req_t            hold_q, cpu_bundle_c, dbg_bundle_c, sel_bundle_c;
   logic [DATA_BITS-1:0] resp_data_c;

   dmem_arb_rr_select u_rr_select (
      .cpu_req    (cpu_req),
      .dbg_req    (dbg_req),
      .last_grant (last_grant_q),
      .grant_c    (grant_c),
      .valid_c    (grant_valid_c)
   );

   // Request bundles for both ports and the one the round-robin picked
   always_comb begin
      cpu_bundle_c = '{we: cpu_we, size: size_e'(cpu_size), sign_ext: cpu_sign_ext,
                       addr: DMEM_ADDR_BITS'(cpu_addr), wdata: DMEM_DATA_BITS'(cpu_wdata)};
      dbg_bundle_c = '{we: dbg_we, size: size_e'(dbg_size), sign_ext: dbg_sign_ext,
                       addr: DMEM_ADDR_BITS'(dbg_addr), wdata: DMEM_DATA_BITS'(dbg_wdata)};
      sel_bundle_c = (grant_c == PORT_DBG) ? dbg_bundle_c : cpu_bundle_c;
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d  = state_q;
      take_c   = 1'b0;
      finish_c = 1'b0;
      unique case (state_q)
         ST_IDLE: begin
            if (grant_valid_c) begin
               state_d = ST_ACCESS;
               take_c  = 1'b1;
            end
         end
         ST_ACCESS: begin
            state_d  = ST_RESP;
            finish_c = 1'b1;
         end
         ST_RESP: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // Grant bookkeeping and hold register; enables are registered so they cover exactly the ACCESS cycle
   always_ff @(posedge clk) begin
      if (!reset) begin
         last_grant_q     <= PORT_DBG;
         owner_q          <= PORT_CPU;
         hold_q           <= '0;
         mem_enable_read  <= 1'b0;
         mem_enable_write <= 1'b0;
      end else begin
         mem_enable_read  <= take_c & ~sel_bundle_c.we;
         mem_enable_write <= take_c & sel_bundle_c.we;
         if (take_c) begin
            last_grant_q <= grant_c;
            owner_q      <= grant_c;
            hold_q       <= sel_bundle_c;
         end
      end
   end

   assign mem_size          = hold_q.size;
   assign mem_sign_ext      = hold_q.sign_ext;
   assign mem_address       = ADDR_BITS'(hold_q.addr);
   assign mem_data_to_write = DATA_BITS'(hold_q.wdata);

   assign resp_data_c = hold_q.we ? '0 : mem_data_read;

   // Response register: captured at the end of ACCESS, presented with the one-cycle ack
   always_ff @(posedge clk) begin
      if (!reset) begin
         cpu_ack   <= 1'b0;
         dbg_ack   <= 1'b0;
         cpu_fault <= 1'b0;
         dbg_fault <= 1'b0;
         cpu_rdata <= '0;
         dbg_rdata <= '0;
      end else begin
         cpu_ack <= finish_c && (owner_q == PORT_CPU);
         dbg_ack <= finish_c && (owner_q == PORT_DBG);
         if (finish_c) begin
            if (owner_q == PORT_CPU) begin
               cpu_rdata <= resp_data_c;
               cpu_fault <= mem_misaligned;
            end else begin
               dbg_rdata <= resp_data_c;
               dbg_fault <= mem_misaligned;
            end
         end
      end
   end

`ifdef DMEM_ARB_STATS_EN
   // Saturating per-port grant counters, bumped on entry to ACCESS
   always_ff @(posedge clk) begin
      if (!reset) begin
         cpu_grants <= '0;
         dbg_grants <= '0;
      end else if (take_c) begin
         if (grant_c == PORT_CPU && cpu_grants != '1) begin
            cpu_grants <= cpu_grants + STAT_BITS'(1);
         end
         if (grant_c == PORT_DBG && dbg_grants != '1) begin
            dbg_grants <= dbg_grants + STAT_BITS'(1);
         end
      end
   end
`endif

endmodule
